data_cal_seq: RTL and testbench

Upstream sequencer for the nibble-sum calculator (`data_cal`). It accepts 16-bit words with a per-word operation mask over a valid/ready handshake and buffers them in a 2-entry FIFO. For each word it drives `data_cal`'s `d`/`sel` pair: one load cycle with `sel=00`, then one cycle per enabled operation (`sel=01/10/11`, ascending). `d`/`sel` connect directly to `data_cal` with no glue logic.

---
 rtl/data_cal_pkg.sv | 30 +++
 rtl/seq_fifo2.sv | 54 +++++
 rtl/data_cal_seq.sv | 101 ++++++++++
 tb/tb_data_cal_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cal_pkg.sv
// Shared definitions for the nibble-sum calculator and its upstream sequencer.
// - sel encodings M0..M3 (M0 loads a word, M1..M3 select an operation)
// - FSM state enum for the sequencer
// - FIFO payload width ({data[15:0], mask[2:0]})
// - mask-walker helpers: lowest enabled operation, and mask with that bit cleared
package data_cal_pkg;

  localparam logic [1:0] M0 = 2'b00;
  localparam logic [1:0] M1 = 2'b01;
  localparam logic [1:0] M2 = 2'b10;
  localparam logic [1:0] M3 = 2'b11;

  localparam int unsigned PAYLOAD_W = 19;

  typedef enum logic [1:0] {IDLE, LOAD, OP} state_e;

  // sel value for the lowest set bit of the remaining mask (M0 when empty)
  function automatic logic [1:0] low_sel(input logic [2:0] m);
    if (m[0])      return M1;
    else if (m[1]) return M2;
    else if (m[2]) return M3;
    else           return M0;
  endfunction

  // Remaining mask once the lowest set bit has been sequenced
  function automatic logic [2:0] clr_low(input logic [2:0] m);
    return m & (m - 3'd1);
  endfunction

endpackage

// File: rtl/seq_fifo2.sv
// Two-entry synchronous FIFO holding {data, mask} words for the sequencer.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   push, wdata     write request and payload (ignored when full without a pop)
//   pop, rdata      read request (ignored when empty) and head-of-queue payload
//   full, empty     occupancy flags derived from the registered count
module seq_fifo2
  import data_cal_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [PAYLOAD_W-1:0] wdata,
  input  logic                 pop,
  output logic [PAYLOAD_W-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  logic [PAYLOAD_W-1:0] mem_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           cnt_q;
  logic                 push_en;
  logic                 pop_en;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign rdata = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot that a push while full would use
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_en} - {1'b0, pop_en};
    end
  end

endmodule

// File: rtl/data_cal_seq.sv
// Upstream sequencer for data_cal. Buffers {word, op mask} pairs in a 2-entry
// FIFO and drives data_cal's d/sel: one load cycle (sel=00) per word followed by
// one cycle per enabled operation in ascending order (01, 10, 11).
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready = FIFO not full
//   in_data, in_mask    word and operation enables (bit0->01, bit1->10, bit2->11)
//   d, sel              registered outputs wired straight to data_cal
//   busy                sequencer not idle
//   word_done           pulse coincident with the last sequenced cycle of a word
//   word_cnt            completed-word count, wraps
module data_cal_seq
  import data_cal_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic [2:0]       in_mask,
  output logic [15:0]      d,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] word_cnt
);

  state_e               state;
  logic [2:0]           mask_r;    // operations still to sequence for the current word
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PAYLOAD_W-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 last;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Current LOAD/OP cycle is the word's final one once nothing is left in the mask
  assign last = (state != IDLE) && (mask_r == 3'b000);

  // Pop from IDLE, or straight out of a word's last cycle to avoid an idle bubble
  assign pop = !fifo_empty && ((state == IDLE) || last);

  seq_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_data, in_mask}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mask_r    <= 3'b000;
      d         <= 16'h0000;
      sel       <= M0;
      word_done <= 1'b0;
      word_cnt  <= '0;
    end else begin
      word_done <= 1'b0;
      if (word_done) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end

      unique case (state)
        IDLE, LOAD, OP: begin
          if (pop) begin
            state     <= LOAD;
            d         <= head[PAYLOAD_W-1:3];
            mask_r    <= head[2:0];
            sel       <= M0;
            word_done <= (head[2:0] == 3'b000);
          end else if (state == IDLE || last) begin
            state <= IDLE;
            sel   <= M0;
          end else begin
            // Walk the mask: lowest remaining enabled operation next
            state     <= OP;
            sel       <= low_sel(mask_r);
            mask_r    <= clr_low(mask_r);
            word_done <= (clr_low(mask_r) == 3'b000);
          end
        end
        default: begin
          state <= IDLE;
          sel   <= M0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cal_seq.sv
module tb_data_cal_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic [2:0]  in_mask;

  logic        in_ready,  in_ready2;
  logic [15:0] d,         d2;
  logic [1:0]  sel,       sel2;
  logic        busy,      busy2;
  logic        word_done, word_done2;
  logic [7:0]  word_cnt;
  logic [1:0]  word_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_cal_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .d         (d),
    .sel       (sel),
    .busy      (busy),
    .word_done (word_done),
    .word_cnt  (word_cnt)
  );

  // Narrow-counter instance sharing the same stimulus
  data_cal_seq #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .d         (d2),
    .sel       (sel2),
    .busy      (busy2),
    .word_done (word_done2),
    .word_cnt  (word_cnt2)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  mask;
    int          n;
    logic [7:0]  sels;  // expected sel per cycle, first cycle in [7:6]
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] d;
    logic        wd;
  } cyc_t;

  vec_t        vecs[6];
  cyc_t        expq[$];
  logic [15:0] bdata[$];
  logic [2:0]  bmask[$];
  logic        saw_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a word and hold it until accepted; returns 1 time unit after the push edge
  task automatic push_word(input logic [15:0] dt, input logic [2:0] m);
    int waitc = 0;
    in_valid = 1'b1;
    in_data  = dt;
    in_mask  = m;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    chk("push_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Reference sequence for one word: load, then each enabled op ascending
  function automatic void add_word(input logic [15:0] dt, input logic [2:0] m);
    cyc_t c;
    c.sel = 2'b00;
    c.d   = dt;
    c.wd  = (m == 3'b000);
    expq.push_back(c);
    for (int b = 0; b < 3; b++) begin
      if (m[b]) begin
        c.sel = 2'(b + 1);
        c.wd  = ((m >> (b + 1)) == 3'b000);
        expq.push_back(c);
      end
    end
  endfunction

  // Compare every queued cycle back to back, then expect idle
  task automatic check_seq(input string tag);
    foreach (expq[i]) begin
      @(posedge clk);
      #1;
      chk({tag, "_sel"},  sel,       expq[i].sel);
      chk({tag, "_d"},    d,         expq[i].d);
      chk({tag, "_wd"},   word_done, expq[i].wd);
      chk({tag, "_busy"}, busy,      1);
    end
    @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_sel"},  sel,  0);
    expq.delete();
  endtask

  task automatic run_burst(input string tag);
    foreach (bmask[i]) add_word(bdata[i], bmask[i]);
    saw_stall = 1'b0;
    fork
      begin
        foreach (bdata[i]) push_word(bdata[i], bmask[i]);
      end
      begin
        @(posedge clk);
        check_seq(tag);
      end
      begin
        repeat (8) begin
          @(negedge clk);
          if (!in_ready) saw_stall = 1'b1;
        end
      end
    join
    bdata.delete();
    bmask.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h4321, 3'b111, 4, 8'b00_01_10_11};
    vecs[1] = '{16'hF00F, 3'b101, 3, 8'b00_01_11_00};
    vecs[2] = '{16'hABCD, 3'b000, 1, 8'b00_00_00_00};
    vecs[3] = '{16'h1234, 3'b010, 2, 8'b00_10_00_00};
    vecs[4] = '{16'h5A5A, 3'b100, 2, 8'b00_11_00_00};
    vecs[5] = '{16'hFFFF, 3'b011, 3, 8'b00_01_10_00};

    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    in_mask  = 3'b000;
    #3;
    chk("rst_d",        d,         0);
    chk("rst_sel",      sel,       0);
    chk("rst_busy",     busy,      0);
    chk("rst_wd",       word_done, 0);
    chk("rst_cnt",      word_cnt,  0);
    chk("rst_in_ready", in_ready,  1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);

    // Single words from idle, hand-computed sel sequences
    for (int i = 0; i < 6; i++) begin
      push_word(vecs[i].data, vecs[i].mask);
      for (int c = 0; c < vecs[i].n; c++) begin
        @(posedge clk);
        #1;
        chk("vec_sel",  sel,       vecs[i].sels[7-2*c -: 2]);
        chk("vec_d",    d,         vecs[i].data);
        chk("vec_wd",   word_done, (c == vecs[i].n - 1));
        chk("vec_busy", busy,      1);
      end
      @(posedge clk);
      #1;
      chk("vec_idle_busy", busy,      0);
      chk("vec_idle_sel",  sel,       0);
      chk("vec_idle_d",    d,         vecs[i].data);
      chk("vec_cnt",       word_cnt,  i + 1);
      chk("vec_cnt2",      word_cnt2, (i + 1) % 4);
      if (i == 4) chk("cnt_w2_after5", word_cnt2, 1);
    end

    // Four back-to-back words with valid held: FIFO fills, no idle gaps
    for (int n = 1; n <= 4; n++) begin
      bdata.push_back(16'(16'h1111 * n));
      bmask.push_back(3'b111);
    end
    run_burst("burst4");
    chk("burst4_stall", saw_stall, 1);
    chk("burst4_cnt",   word_cnt,  10);
    chk("burst4_cnt2",  word_cnt2, 2);

    // Mask 000 word sandwiched between full-mask words
    bdata.push_back(16'h0A0A); bmask.push_back(3'b111);
    bdata.push_back(16'h0B0B); bmask.push_back(3'b000);
    bdata.push_back(16'h0C0C); bmask.push_back(3'b111);
    run_burst("mask0");
    chk("mask0_cnt", word_cnt, 13);

    // Reset during the second OP with one word buffered
    push_word(16'h7777, 3'b111);
    push_word(16'h8888, 3'b001);
    @(posedge clk);
    #1;
    chk("mid_op1_sel", sel, 2'b01);
    @(posedge clk);
    #1;
    chk("mid_op2_sel", sel, 2'b10);
    rst = 1'b0;
    #1;
    chk("mid_rst_sel",      sel,       0);
    chk("mid_rst_d",        d,         0);
    chk("mid_rst_busy",     busy,      0);
    chk("mid_rst_in_ready", in_ready,  1);
    chk("mid_rst_wd",       word_done, 0);
    chk("mid_rst_cnt",      word_cnt,  0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("after_rst_busy", busy, 0);
      chk("after_rst_sel",  sel,  0);
    end

    // Fresh word after the flush
    push_word(16'h9999, 3'b100);
    add_word(16'h9999, 3'b100);
    check_seq("post_rst");
    chk("post_rst_cnt", word_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
